mem_port_arbiter: RTL and testbench

Sequencing arbiter that shares the single byte-addressed, big-endian 512-byte data memory between the instruction-fetch port (I, word reads only) and the load/store port (D, byte/halfword/word, read/write, optional sign extension). It sits between the pipeline's fetch/memory stages and the memory, and owns every memory control signal. It grants one requester at a time, checks alignment, drives the memory for exactly one cycle, and returns registered read data with a one-cycle acknowledge.

---
 rtl/mem_arb_pkg.sv | 35 +++
 rtl/mem_align_check.sv | 22 ++
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter: widths, FSM state
// encoding, access-size codes, requester ids and the latched request record.
package mem_arb_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Access size codes as seen on DSize / MemSize (2'b11 also means word).
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Requester identity, used for round-robin tie breaking and ack routing.
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  // Everything the arbiter captures at grant time and replays to memory.
  typedef struct packed {
    logic              rw;
    logic [1:0]        size;
    logic              se;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_align_check.sv
// Combinational alignment check for a big-endian byte-addressed memory.
// Bytes are always aligned, halfwords need addr[0]==0, words (size 10 or 11)
// need addr[1:0]==00.
module mem_align_check
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr_lo,
  output logic       o_misaligned
);

  // Decode the size code and test the low address bits it cares about.
  always_comb begin
    o_misaligned = 1'b0;
    case (i_size)
      SIZE_BYTE: o_misaligned = 1'b0;
      SIZE_HALF: o_misaligned = i_addr_lo[0];
      default:   o_misaligned = (i_addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 512-byte data memory between the fetch port (I, word reads) and
// the load/store port (D). One access at a time: grant in IDLE, drive memory
// for one cycle in ACCESS, acknowledge in DONE. Misaligned requests skip
// ACCESS and are acknowledged with an error straight from IDLE.
//
// Handshake: a requester raises Req with stable request fields and holds it
// until it samples Ack high at a rising edge; Ack is a one-cycle registered
// pulse and Rdata/Err are valid in that same cycle. Fields are latched at
// grant, so the requester may change them once Ack has been seen.
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  // Fetch port
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddress,
  output logic              IAck,
  output logic              IErr,
  output logic [DATA_W-1:0] IRdata,
  // Load/store port
  input  logic              DReq,
  input  logic              DReadWrite,
  input  logic [1:0]        DSize,
  input  logic              DSE,
  input  logic [ADDR_W-1:0] DAddress,
  input  logic [DATA_W-1:0] DWdata,
  output logic              DAck,
  output logic              DErr,
  output logic [DATA_W-1:0] DRdata,
  // Memory side
  output logic              MemEnable,
  output logic              MemReadWrite,
  output logic              MemSE,
  output logic [1:0]        MemSize,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemDataIn,
  input  logic [DATA_W-1:0] MemDataOut,
  // Current FSM state, for observation only
  output state_t            DbgState
);

  state_t            r_state;
  state_t            w_next;
  port_t             r_last;
  port_t             r_port;
  mem_req_t          r_req;
  mem_req_t          w_req;
  logic              w_any_req;
  logic              w_win_d;
  logic              w_grant;
  logic              w_misaligned;
  logic              w_mem_en;
  logic [DATA_W-1:0] w_resp;

  logic              r_iack;
  logic              r_ierr;
  logic [DATA_W-1:0] r_irdata;
  logic              r_dack;
  logic              r_derr;
  logic [DATA_W-1:0] r_drdata;

  assign w_any_req = IReq | DReq;
  // D wins when alone, or on a tie when I was the previous grantee.
  assign w_win_d   = DReq & (~IReq | (r_last == PORT_I));
  assign w_grant   = (r_state == IDLE) & w_any_req;

  // Build the candidate request from the winning port; fetches are word
  // reads without sign extension, and SE is meaningless for stores.
  always_comb begin
    w_req.rw    = 1'b0;
    w_req.size  = SIZE_WORD;
    w_req.se    = 1'b0;
    w_req.addr  = IAddress;
    w_req.wdata = '0;
    if (w_win_d) begin
      w_req.rw    = DReadWrite;
      w_req.size  = DSize;
      w_req.se    = DSE & ~DReadWrite;
      w_req.addr  = DAddress;
      w_req.wdata = DWdata;
    end
  end

  // One checker serves both ports because it sits after the grant mux.
  mem_align_check u_align (
    .i_size       (w_req.size),
    .i_addr_lo    (w_req.addr[1:0]),
    .o_misaligned (w_misaligned)
  );

  // State register; reset abandons any in-flight access.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: misaligned grants bypass the memory cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_any_req) w_next = w_misaligned ? DONE : ACCESS;
      end
      ACCESS:  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latch the winning request and remember who was granted.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_last <= PORT_I;
      r_port <= PORT_I;
      r_req  <= '0;
    end else if (w_grant) begin
      r_last <= w_win_d ? PORT_D : PORT_I;
      r_port <= w_win_d ? PORT_D : PORT_I;
      r_req  <= w_req;
    end
  end

  // Stores return zero; loads return whatever the memory presents.
  assign w_resp = r_req.rw ? '0 : MemDataOut;

  // Registered responses: Ack/Err pulse for one cycle, Rdata holds its value.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_iack   <= 1'b0;
      r_ierr   <= 1'b0;
      r_irdata <= '0;
      r_dack   <= 1'b0;
      r_derr   <= 1'b0;
      r_drdata <= '0;
    end else begin
      r_iack <= 1'b0;
      r_ierr <= 1'b0;
      r_dack <= 1'b0;
      r_derr <= 1'b0;
      if (w_grant && w_misaligned) begin
        if (w_win_d) begin
          r_dack   <= 1'b1;
          r_derr   <= 1'b1;
          r_drdata <= '0;
        end else begin
          r_iack   <= 1'b1;
          r_ierr   <= 1'b1;
          r_irdata <= '0;
        end
      end else if (r_state == ACCESS) begin
        if (r_port == PORT_D) begin
          r_dack   <= 1'b1;
          r_drdata <= w_resp;
        end else begin
          r_iack   <= 1'b1;
          r_irdata <= w_resp;
        end
      end
    end
  end

  assign IAck   = r_iack;
  assign IErr   = r_ierr;
  assign IRdata = r_irdata;
  assign DAck   = r_dack;
  assign DErr   = r_derr;
  assign DRdata = r_drdata;

  // Memory controls come only from state and latched fields, and are all
  // forced to zero outside the single ACCESS cycle.
  assign w_mem_en     = (r_state == ACCESS);
  assign MemEnable    = w_mem_en;
  assign MemReadWrite = w_mem_en & r_req.rw;
  assign MemSE        = w_mem_en & r_req.se;
  assign MemSize      = w_mem_en ? r_req.size  : 2'b00;
  assign MemAddress   = w_mem_en ? r_req.addr  : '0;
  assign MemDataIn    = w_mem_en ? r_req.wdata : '0;

  assign DbgState = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a big-endian 512-byte memory model.
// Drivers push expected {port_is_d, err, rdata} entries; a negedge monitor pops
// one entry per Ack and compares.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        IReq = 1'b0;
  logic [8:0]  IAddress = '0;
  logic        IAck, IErr;
  logic [31:0] IRdata;
  logic        DReq = 1'b0;
  logic        DReadWrite = 1'b0;
  logic [1:0]  DSize = 2'b00;
  logic        DSE = 1'b0;
  logic [8:0]  DAddress = '0;
  logic [31:0] DWdata = '0;
  logic        DAck, DErr;
  logic [31:0] DRdata;
  logic        MemEnable, MemReadWrite, MemSE;
  logic [1:0]  MemSize;
  logic [8:0]  MemAddress;
  logic [31:0] MemDataIn;
  logic [31:0] MemDataOut;
  state_t      DbgState;

  logic [33:0] exp_q[$];
  logic [33:0] mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  int          exp_en = 0;
  int          seen_en = 0;
  logic [7:0]  mem [0:511];

  mem_port_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .IReq(IReq), .IAddress(IAddress), .IAck(IAck), .IErr(IErr), .IRdata(IRdata),
    .DReq(DReq), .DReadWrite(DReadWrite), .DSize(DSize), .DSE(DSE),
    .DAddress(DAddress), .DWdata(DWdata), .DAck(DAck), .DErr(DErr), .DRdata(DRdata),
    .MemEnable(MemEnable), .MemReadWrite(MemReadWrite), .MemSE(MemSE),
    .MemSize(MemSize), .MemAddress(MemAddress), .MemDataIn(MemDataIn),
    .MemDataOut(MemDataOut), .DbgState(DbgState)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- memory model ----------------
  initial begin
    for (int i = 0; i < 512; i++) mem[i] <= i[7:0];
  end

  always @(posedge Clk) begin
    if (MemEnable && MemReadWrite) begin
      case (MemSize)
        2'b00: mem[MemAddress] <= MemDataIn[7:0];
        2'b01: begin
          mem[MemAddress]        <= MemDataIn[15:8];
          mem[MemAddress + 9'd1] <= MemDataIn[7:0];
        end
        default: begin
          mem[MemAddress]        <= MemDataIn[31:24];
          mem[MemAddress + 9'd1] <= MemDataIn[23:16];
          mem[MemAddress + 9'd2] <= MemDataIn[15:8];
          mem[MemAddress + 9'd3] <= MemDataIn[7:0];
        end
      endcase
    end
  end

  always_comb begin
    case (MemSize)
      2'b00: MemDataOut = {{24{MemSE & mem[MemAddress][7]}}, mem[MemAddress]};
      2'b01: MemDataOut = {{16{MemSE & mem[MemAddress][7]}}, mem[MemAddress],
                           mem[MemAddress + 9'd1]};
      default: MemDataOut = {mem[MemAddress], mem[MemAddress + 9'd1],
                             mem[MemAddress + 9'd2], mem[MemAddress + 9'd3]};
    endcase
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge Clk) begin
    if (!Reset) begin
      if (MemEnable) seen_en++;
      else check("mem_idle_zero", {MemReadWrite, MemSE, MemSize, MemAddress, MemDataIn}, 64'd0);
      check("ack_exclusive", {63'd0, IAck & DAck}, 64'd0);
      if (IAck || DAck) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: got IAck=%0b DAck=%0b, expected no ack", IAck, DAck);
        end else begin
          mon_e = exp_q.pop_front();
          check("ack_port", {63'd0, DAck}, {63'd0, mon_e[33]});
          check("ack_err", {63'd0, (DAck ? DErr : IErr)}, {63'd0, mon_e[32]});
          check("ack_rdata", {32'd0, (DAck ? DRdata : IRdata)}, {32'd0, mon_e[31:0]});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // Call at posedge+1; raises the request now, returns at posedge+1 with it low.
  task automatic d_req(input logic rw, input logic [1:0] size, input logic se,
                       input logic [8:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input int exp_lat);
    int n;
    bit got;
    DReadWrite = rw; DSize = size; DSE = se; DAddress = addr; DWdata = wdata;
    DReq = 1'b1;
    if (!exp_err) exp_en++;
    n = 0;
    got = 0;
    while (!got && n < 20) begin
      @(posedge Clk); n++;
      @(negedge Clk);
      if (DAck) got = 1;
    end
    if (!got) check("d_ack_timeout", 64'd0, 64'd1);
    else if (exp_lat > 0) check("d_latency", n, exp_lat);
    @(posedge Clk); #1;
    DReq = 1'b0;
  endtask

  task automatic i_req(input logic [8:0] addr, input logic exp_err, input int exp_lat);
    int n;
    bit got;
    IAddress = addr;
    IReq = 1'b1;
    if (!exp_err) exp_en++;
    n = 0;
    got = 0;
    while (!got && n < 20) begin
      @(posedge Clk); n++;
      @(negedge Clk);
      if (IAck) got = 1;
    end
    if (!got) check("i_ack_timeout", 64'd0, 64'd1);
    else if (exp_lat > 0) check("i_latency", n, exp_lat);
    @(posedge Clk); #1;
    IReq = 1'b0;
  endtask

  task automatic d_txn(input logic rw, input logic [1:0] size, input logic se,
                       input logic [8:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_data, input int exp_lat);
    exp_q.push_back({1'b1, exp_err, exp_data});
    d_req(rw, size, se, addr, wdata, exp_err, exp_lat);
  endtask

  task automatic i_txn(input logic [8:0] addr, input logic exp_err,
                       input logic [31:0] exp_data, input int exp_lat);
    exp_q.push_back({1'b0, exp_err, exp_data});
    i_req(addr, exp_err, exp_lat);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    #1 Reset = 1'b1;
    #1;
    check("rst_outputs", {IAck, IErr, DAck, DErr, MemEnable, MemReadWrite, MemSE, MemSize},
          64'd0);
    check("rst_rdata", {IRdata, DRdata}, 64'd0);
    check("rst_mem_bus", {MemAddress, MemDataIn}, 64'd0);
    check("rst_state", DbgState, IDLE);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(posedge Clk); #1;

    // Store/load round trip and sub-word loads
    d_txn(1'b1, SIZE_WORD, 1'b0, 9'h010, 32'hDEADBEEF, 1'b0, 32'h0, 2);
    d_txn(1'b0, SIZE_WORD, 1'b0, 9'h010, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    d_txn(1'b0, SIZE_BYTE, 1'b1, 9'h010, 32'h0, 1'b0, 32'hFFFFFFDE, 2);
    d_txn(1'b0, SIZE_HALF, 1'b0, 9'h012, 32'h0, 1'b0, 32'h0000BEEF, 2);
    d_txn(1'b0, SIZE_HALF, 1'b0, 9'h011, 32'h0, 1'b1, 32'h0, 1);
    d_txn(1'b0, SIZE_BYTE, 1'b0, 9'h011, 32'h0, 1'b0, 32'h000000AD, 2);
    d_txn(1'b0, SIZE_HALF, 1'b1, 9'h010, 32'h0, 1'b0, 32'hFFFFDEAD, 2);
    // Sub-word stores, read back as words (size 11 also means word)
    d_txn(1'b1, SIZE_BYTE, 1'b0, 9'h030, 32'h123456AB, 1'b0, 32'h0, 2);
    d_txn(1'b0, 2'b11,     1'b0, 9'h030, 32'h0, 1'b0, 32'hAB313233, 2);
    d_txn(1'b1, SIZE_HALF, 1'b0, 9'h040, 32'hFFFF1234, 1'b0, 32'h0, 2);
    d_txn(1'b0, SIZE_WORD, 1'b0, 9'h040, 32'h0, 1'b0, 32'h12344243, 2);
    // Top-of-memory boundary and misaligned words
    d_txn(1'b0, SIZE_WORD, 1'b0, 9'h1FC, 32'h0, 1'b0, 32'hFCFDFEFF, 2);
    d_txn(1'b0, SIZE_WORD, 1'b0, 9'h1FE, 32'h0, 1'b1, 32'h0, 1);
    d_txn(1'b1, SIZE_WORD, 1'b0, 9'h013, 32'h01020304, 1'b1, 32'h0, 1);
    d_txn(1'b0, SIZE_WORD, 1'b0, 9'h010, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    d_txn(1'b0, SIZE_BYTE, 1'b1, 9'h1FF, 32'h0, 1'b0, 32'hFFFFFFFF, 2);
    d_txn(1'b0, SIZE_BYTE, 1'b1, 9'h07F, 32'h0, 1'b0, 32'h0000007F, 2);
    // Fetch port
    i_txn(9'h020, 1'b0, 32'h20212223, 2);
    i_txn(9'h022, 1'b1, 32'h0, 1);
    i_txn(9'h1FC, 1'b0, 32'hFCFDFEFF, 2);

    // Contention: last grant was I, so D wins first, then strict alternation
    exp_q.push_back({1'b1, 1'b0, 32'h50515253});
    exp_q.push_back({1'b0, 1'b0, 32'h60616263});
    exp_q.push_back({1'b1, 1'b0, 32'h54555657});
    exp_q.push_back({1'b0, 1'b0, 32'h64656667});
    fork
      begin
        d_req(1'b0, SIZE_WORD, 1'b0, 9'h050, 32'h0, 1'b0, 0);
        d_req(1'b0, SIZE_WORD, 1'b0, 9'h054, 32'h0, 1'b0, 0);
      end
      begin
        i_req(9'h060, 1'b0, 0);
        i_req(9'h064, 1'b0, 0);
      end
    join

    // Reset during ACCESS
    DReadWrite = 1'b0; DSize = SIZE_WORD; DSE = 1'b0; DAddress = 9'h010;
    DReq = 1'b1;
    @(posedge Clk); #1;
    check("abort_in_access", DbgState, ACCESS);
    check("abort_mem_en_before", {63'd0, MemEnable}, 64'd1);
    #1 Reset = 1'b1;
    #1;
    check("abort_mem_en_drop", {63'd0, MemEnable}, 64'd0);
    check("abort_acks", {62'd0, IAck, DAck}, 64'd0);
    check("abort_state_idle", DbgState, IDLE);
    DReq = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    // First tie after reset goes to D
    exp_q.push_back({1'b1, 1'b0, 32'h20212223});
    exp_q.push_back({1'b0, 1'b0, 32'h24252627});
    fork
      d_req(1'b0, SIZE_WORD, 1'b0, 9'h020, 32'h0, 1'b0, 0);
      i_req(9'h024, 1'b0, 0);
    join

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge Clk);
      guard++;
    end
    repeat (3) @(posedge Clk);
    check("queue_drained", exp_q.size(), 64'd0);
    check("mem_en_pulses", seen_en, exp_en);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
